dsp_result_drain: RTL and testbench

Output stage placed directly downstream of `dsp_slice`. It captures the slice's paired 37-bit results (`resulta`, `resultb`) and applies a round-half-up arithmetic right shift to each lane. It then saturates each lane to a narrow signed width and buffers the packed pair in a small FIFO. Consumers downstream read from that FIFO over a valid/ready handshake.

---
 rtl/dsp_result_drain.sv | 106 ++++++++++
 tb/tb_dsp_result_drain.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dsp_result_drain.sv
// Output stage for dsp_slice: rounds and shifts each 37-bit result lane, then saturates it.
// The packed pair goes into a show-ahead FIFO that is drained over valid/ready.
module dsp_result_drain #(
    parameter int IN_W  = 37,
    parameter int OUT_W = 18,
    parameter int SHIFT = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         in_valid,
    input  logic [IN_W-1:0]              resulta,
    input  logic [IN_W-1:0]              resultb,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*OUT_W-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [15:0]                  sat_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = IN_W + 1;

    localparam logic [EW-1:0] RND =
        (SHIFT > 0) ? (EW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Returns {clipped, lane value}
    function automatic logic [OUT_W:0] sat_lane(input logic signed [EW-1:0] v);
        if (v > SAT_MAX)
            return {1'b1, SAT_MAX[OUT_W-1:0]};
        else if (v < SAT_MIN)
            return {1'b1, SAT_MIN[OUT_W-1:0]};
        else
            return {1'b0, v[OUT_W-1:0]};
    endfunction

    logic                  s1_vld_q;
    logic signed [EW-1:0]  s1a_q, s1b_q;
    logic signed [EW-1:0]  a_rs, b_rs;
    logic [2*OUT_W-1:0]    mem_q [DEPTH];
    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]         occ_q, occ_d;
    logic [15:0]           sat_q, sat_d;
    logic [OUT_W:0]        sat_a, sat_b;
    logic                  accept, push, pop, clip;

    // Extending by one bit first keeps the rounding add from overflowing
    assign a_rs = ($signed({resulta[IN_W-1], resulta}) + $signed(RND)) >>> SHIFT;
    assign b_rs = ($signed({resultb[IN_W-1], resultb}) + $signed(RND)) >>> SHIFT;

    assign sat_a = sat_lane(s1a_q);
    assign sat_b = sat_lane(s1b_q);
    assign clip  = sat_a[OUT_W] | sat_b[OUT_W];

    // Counting the stage-1 sample guarantees it always has a FIFO slot
    assign in_ready  = ({1'b0, occ_q} + {{CW{1'b0}}, s1_vld_q}) < (CW+1)'(DEPTH);
    assign out_valid = (occ_q != '0);
    assign accept    = in_valid & in_ready;
    assign push      = s1_vld_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_d  = push ? wr_q + 1'b1 : wr_q;
        rd_d  = pop  ? rd_q + 1'b1 : rd_q;
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        sat_d = (push && clip && sat_q != 16'hFFFF) ? sat_q + 16'd1 : sat_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            s1_vld_q <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            occ_q    <= '0;
            sat_q    <= '0;
        end else begin
            s1_vld_q <= accept;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            occ_q    <= occ_d;
            sat_q    <= sat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr && accept) begin
            s1a_q <= a_rs;
            s1b_q <= b_rs;
        end
        if (!clr && push)
            mem_q[wr_q] <= {sat_b[OUT_W-1:0], sat_a[OUT_W-1:0]};
    end

    // Storage is not cleared; the empty mask hides stale entries
    assign out_data  = out_valid ? mem_q[rd_q] : '0;
    assign occupancy = occ_q;
    assign sat_count = sat_q;
endmodule

// File: tb/tb_dsp_result_drain.sv
// Randomized and directed bench for dsp_result_drain, checked against a queue-based
// transaction model computed with plain integer arithmetic.
module tb_dsp_result_drain;
    localparam int IN_W = 37, OUT_W = 18, SHIFT = 8, DEPTH = 4;

    logic               clk = 1'b0;
    logic               clr, in_valid, out_ready;
    logic [IN_W-1:0]    resulta, resultb;
    logic               in_ready, out_valid;
    logic [2*OUT_W-1:0] out_data;
    logic [2:0]         occupancy;
    logic [15:0]        sat_count;

    int n_cmp = 0, n_err = 0;

    // Model state: one sample in flight plus a queue of buffered results
    bit                 m_sv;
    logic [2*OUT_W-1:0] m_sd;
    bit                 m_sclip;
    logic [2*OUT_W-1:0] mq[$];
    int                 m_sat;

    dsp_result_drain #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .resulta(resulta), .resultb(resultb),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .occupancy(occupancy), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Round half up to 2^-SHIFT, then clip to the signed OUT_W range
    function automatic logic [OUT_W-1:0] ref_lane(input logic [IN_W-1:0] x, output bit clipped);
        longint v, lo, hi, unit;
        v    = longint'($signed(x));
        unit = longint'(1) << SHIFT;
        v    = v + unit / 2;
        v    = (v >= 0) ? v / unit : -((-v + unit - 1) / unit);
        hi   = (longint'(1) << (OUT_W-1)) - 1;
        lo   = -(longint'(1) << (OUT_W-1));
        clipped = 1'b0;
        if (v > hi) begin v = hi; clipped = 1'b1; end
        if (v < lo) begin v = lo; clipped = 1'b1; end
        return OUT_W'(v);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_sv = 0; m_sat = 0; m_sd = '0; m_sclip = 0;
    endtask

    // Drive one cycle, check pre-edge outputs, advance the model across the edge
    task automatic step(input bit c, input bit iv, input logic [IN_W-1:0] a,
                        input logic [IN_W-1:0] b, input bit ordy);
        bit exp_rdy, ca, cb;
        logic [OUT_W-1:0] la, lb;
        clr = c; in_valid = iv; resulta = a; resultb = b; out_ready = ordy;
        #1;
        exp_rdy = (mq.size() + int'(m_sv)) < DEPTH;
        chk("in_ready",  64'(in_ready),  64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("sat_count", 64'(sat_count), 64'(m_sat));
        chk("out_data",  64'(out_data),  (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
        @(posedge clk);
        if (c) model_reset();
        else begin
            if (mq.size() != 0 && ordy) void'(mq.pop_front());
            if (m_sv) begin
                mq.push_back(m_sd);
                if (m_sclip && m_sat < 65535) m_sat++;
            end
            m_sv = iv && exp_rdy;
            if (m_sv) begin
                la = ref_lane(a, ca);
                lb = ref_lane(b, cb);
                m_sd = {lb, la};
                m_sclip = ca | cb;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [IN_W-1:0] rand_val();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0: return IN_W'($signed(r[19:0]));
            1: return IN_W'(((longint'(1) << 25) - 1) + longint'($urandom_range(0, 512)) - 256);
            2: return IN_W'(-(longint'(1) << 25) + longint'($urandom_range(0, 512)) - 256);
            3: return IN_W'((longint'($signed(r[15:0])) <<< SHIFT) + 128);
            default: return IN_W'(r);
        endcase
    endfunction

    initial begin
        int idx;
        clr = 1'b1; in_valid = 1'b1; out_ready = 1'b0; resulta = '0; resultb = '0;
        model_reset();
        @(negedge clk);

        // Reset held two cycles with in_valid asserted
        step(1, 1, 37'd512, 37'd512, 1);
        step(1, 1, 37'd512, 37'd512, 1);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        step(0, 0, '0, '0, 1);
        step(0, 0, '0, '0, 1);

        // Rounding
        step(0, 1, 37'd384, 37'd383, 1);
        step(0, 1, 37'(-384), 37'd0, 1);
        chk("round_pair", 64'(out_data), 64'({18'd1, 18'd2}));
        step(0, 0, '0, '0, 1);
        chk("round_neg", 64'(out_data[OUT_W-1:0]), 64'(18'h3FFFF));
        step(0, 0, '0, '0, 1);

        // Saturation, then an in-range sample
        step(0, 1, 37'(1073741824), 37'(-1073741824), 1);
        step(0, 1, 37'd1000, 37'd2000, 1);
        chk("sat_pair", 64'(out_data), 64'({18'h20000, 18'h1FFFF}));
        chk("sat_cnt1", 64'(sat_count), 64'd1);
        step(0, 0, '0, '0, 1);
        step(0, 0, '0, '0, 1);
        chk("sat_cnt_hold", 64'(sat_count), 64'd1);

        // Backpressure: source holds each value until accepted
        idx = 1;
        for (int i = 0; i < 8; i++) begin
            bit acc;
            acc = in_ready;
            step(0, 1, IN_W'(idx << 8), IN_W'(idx << 8), 0);
            if (acc) idx++;
        end
        chk("bp_accepted", 64'(idx - 1), 64'd4);
        chk("bp_occ", 64'(occupancy), 64'd4);
        chk("bp_ready", 64'(in_ready), 64'd0);
        chk("bp_head", 64'(out_data[OUT_W-1:0]), 64'd1);
        step(0, 1, IN_W'(idx << 8), IN_W'(idx << 8), 1);
        chk("bp_reready", 64'(in_ready), 64'd1);
        step(0, 1, IN_W'(idx << 8), IN_W'(idx << 8), 0);
        for (int i = 0; i < 2; i++) step(0, 0, '0, '0, 0);
        chk("bp_head2", 64'(out_data[OUT_W-1:0]), 64'd2);
        for (int i = 0; i < 8; i++) step(0, 0, '0, '0, 1);

        // Steady state push/pop at occupancy 2 across pointer wrap
        for (int i = 0; i < 3; i++) step(0, 1, rand_val(), rand_val(), 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, rand_val(), rand_val(), 1);
            chk("steady_occ", 64'(occupancy), 64'd2);
        end
        for (int i = 0; i < 6; i++) step(0, 0, '0, '0, 1);

        // Reset mid-operation: three buffered plus one in stage 1
        for (int i = 0; i < 4; i++) step(0, 1, rand_val(), rand_val(), 0);
        chk("mid_occ", 64'(occupancy), 64'd3);
        step(1, 1, rand_val(), rand_val(), 0);
        chk("mid_valid", 64'(out_valid), 64'd0);
        chk("mid_occ0", 64'(occupancy), 64'd0);
        chk("mid_sat0", 64'(sat_count), 64'd0);
        for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 rand_val(), rand_val(), $urandom_range(0, 2) != 0);
        for (int i = 0; i < 8; i++) step(0, 0, '0, '0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
